fir_sample_feeder: RTL and testbench

Sample-rate source for the FIR/IIR filter input. Accepts signed samples from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. Presents exactly one sample per sample period on `Xin` with a one-cycle `x_strobe`, and zero-fills with an underrun count when starved. It sits between the stimulus/ADC-side logic and the filter's `Xin` port.

---
 rtl/fir_sample_feeder.sv | 165 ++++++++++++++++
 tb/tb_fir_sample_feeder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
//
// Sample-rate source for the filter input. Samples arrive from a producer
// over a valid/ready handshake and are buffered in a circular FIFO. Once
// streaming, exactly one sample is presented on Xin every DIV cycles with a
// one-cycle x_strobe. When the FIFO is starved, the period emits 0 and
// underrun_cnt is bumped (saturating).
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered level, never on in_valid or on a pop
// in the same cycle.
//
// Ports:
//   sys_clk, sys_rst      clock, asynchronous active-high reset
//   in_data/in_valid      producer sample and its qualifier
//   in_ready              FIFO not full
//   start, stop, flush    one-cycle control pulses
//   Xin, x_strobe         registered output sample and its new-value pulse
//   level                 FIFO occupancy 0..DEPTH
//   underrun_cnt          saturating count of zero-filled periods
//   busy                  high in PRIME or RUN
//   state                 FSM state for observation (0 IDLE, 1 PRIME, 2 RUN)
module fir_sample_feeder #(
    parameter int DW        = 3,
    parameter int DEPTH     = 8,
    parameter int DIV       = 4,
    parameter int PRIME_LVL = 2
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     flush,
    output logic [DW-1:0]            Xin,
    output logic                     x_strobe,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               underrun_cnt,
    output logic                     busy,
    output logic [1:0]               state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIV);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_PRIME = LW'(PRIME_LVL);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic push;
    logic pop;
    logic halt;
    logic sample_event;
    logic underrun_evt;

    always_comb begin
        in_ready     = (level != LVL_FULL);
        busy         = (state != ST_IDLE);
        push         = in_valid && in_ready && !flush;
        halt         = stop && busy;
        // stop suppresses the event even on the last cycle of a period.
        sample_event = (state == ST_RUN) && !stop && (cnt == CNT_MAX);
        // No bypass: a sample pushed this cycle cannot be popped this cycle,
        // and a flush in the event cycle leaves nothing to pop.
        pop          = sample_event && (level != '0) && !flush;
        underrun_evt = sample_event && !pop;
    end

    // Storage has no reset; contents are only meaningful below level.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start) state <= ST_PRIME;
                end
                ST_PRIME: begin
                    cnt <= '0;
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (level >= LVL_PRIME) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            Xin          <= '0;
            x_strobe     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            x_strobe <= sample_event;
            if (halt) begin
                Xin <= '0;
            end else if (sample_event) begin
                Xin <= pop ? mem[rd_ptr] : '0;
            end

            if ((state == ST_IDLE) && start) begin
                underrun_cnt <= '0;
            end else if (underrun_evt && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;
  localparam int DW        = 3;
  localparam int DEPTH     = 8;
  localparam int DIV       = 4;
  localparam int PRIME_LVL = 2;
  localparam int LW        = $clog2(DEPTH) + 1;

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          flush = 1'b0;
  logic          in_ready;
  logic [DW-1:0] Xin;
  logic          x_strobe;
  logic [LW-1:0] level;
  logic [7:0]    underrun_cnt;
  logic          busy;
  logic [1:0]    state;

  always #5 clk = ~clk;

  fir_sample_feeder #(
    .DW(DW), .DEPTH(DEPTH), .DIV(DIV), .PRIME_LVL(PRIME_LVL)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .stop(stop), .flush(flush),
    .Xin(Xin), .x_strobe(x_strobe), .level(level),
    .underrun_cnt(underrun_cnt), .busy(busy), .state(state)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  int            m_mode = M_IDLE;
  int            m_phase = 0;
  int            m_under = 0;
  logic [DW-1:0] m_xin = '0;

  int checks = 0;
  int failures = 0;
  bit last_strobe = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_mode  = M_IDLE;
    m_phase = 0;
    m_under = 0;
    m_xin   = '0;
  endtask

  // One clock edge of the sample feeder's behaviour, driven by the inputs
  // the bench applied for that edge.
  task automatic model_step();
    int            sz;
    bit            acc;
    bit            ev;
    logic [DW-1:0] v;
    sz  = m_q.size();
    acc = in_valid && (sz < DEPTH) && !flush;
    ev  = (m_mode == M_RUN) && !stop && (m_phase == DIV - 1);
    if (ev) begin
      if (sz > 0 && !flush) begin
        v = m_q.pop_front();
      end else begin
        v = '0;
        if (m_under < 255) m_under++;
      end
      exp_q.push_back(v);
      m_xin = v;
    end
    if (flush) m_q.delete();
    if (acc) m_q.push_back(in_data);
    case (m_mode)
      M_IDLE: if (start) begin
        m_mode  = M_PRIME;
        m_under = 0;
      end
      M_PRIME: if (stop) begin
        m_mode = M_IDLE;
        m_xin  = '0;
      end else if (sz >= PRIME_LVL) begin
        m_mode  = M_RUN;
        m_phase = 0;
      end
      default: if (stop) begin
        m_mode  = M_IDLE;
        m_phase = 0;
        m_xin   = '0;
      end else begin
        m_phase = (m_phase + 1) % DIV;
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [DW-1:0] d,
                      input bit st, input bit sp, input bit fl);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    start    = st;
    stop     = sp;
    flush    = fl;
    @(posedge clk);
    if (sys_rst) model_reset();
    else model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance until the next edge is a sample-event edge in RUN.
  task automatic wait_event_cycle();
    int n;
    n = 0;
    while (!(m_mode == M_RUN && m_phase == DIV - 1) && n < 64) begin
      idle(1);
      n++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $display("FAIL wait_event_cycle: timeout after %0d cycles", n);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2 sys_rst = 1'b1;
    in_valid = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    flush = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    @(posedge clk);
    model_step();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    chk("level", int'(level), m_q.size());
    chk("in_ready", int'(in_ready), (m_q.size() != DEPTH) ? 1 : 0);
    chk("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
    chk("underrun_cnt", int'(underrun_cnt), m_under);
    chk("xin_hold", int'(Xin), int'(m_xin));
    if (x_strobe) begin
      chk("strobe_back_to_back", int'(last_strobe), 0);
      chk("unexpected_strobe", (exp_q.size() == 0) ? 1 : 0, 0);
      if (exp_q.size() > 0) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk("strobe_xin", int'(Xin), int'(e));
      end
    end else begin
      chk("missing_strobe", exp_q.size(), 0);
      exp_q.delete();
    end
    last_strobe = x_strobe;
  end

  // ---------------- stimulus ----------------
  int vals[4] = '{3, -1, 2, -4};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    @(posedge clk);
    model_step();
    idle(4);

    // Basic stream: four samples then underruns.
    for (int i = 0; i < 4; i++) push(DW'(vals[i]));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(40);

    // Empty-edge race: push lands on the sample-event edge with level 0.
    wait_event_cycle();
    push(DW'(1));
    idle(10);

    // stop exactly on a sample-event cycle, then flush, then re-prime.
    push(DW'(2));
    push(DW'(3));
    push(DW'(5));
    wait_event_cycle();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("stop_busy", int'(busy), 0);
    chk("stop_xin", int'(Xin), 0);
    idle(6);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("flush_level", int'(level), 0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(12);
    chk("prime_state", int'(state), 1);
    push(DW'(6));
    idle(6);
    push(DW'(7));
    idle(20);

    // Back-pressure: fill while idle, then drain across pointer wrap.
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) push(DW'($urandom_range(0, 7)));
    #1;
    chk("full_level", int'(level), DEPTH);
    chk("full_ready", int'(in_ready), 0);
    step(1'b1, DW'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++) push(DW'($urandom_range(0, 7)));
    idle(50);

    // Random traffic with occasional control pulses.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 30, DW'($urandom_range(0, 7)),
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) < 1);
    end

    // Saturation of the underrun counter.
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    push(DW'(1));
    push(DW'(2));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(DIV * 300 + 20);
    #1;
    chk("sat_underrun", int'(underrun_cnt), 255);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("sat_clear", int'(underrun_cnt), 0);
    push(DW'(4));
    push(DW'(3));
    idle(30);

    // Mid-run reset, then quiet for 100 cycles.
    do_reset(3);
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_xin", int'(Xin), 0);
    idle(100);

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
